mul_div_exec_unit: RTL
======================

# mul_div_exec_unit

Multi-cycle multiply/divide functional unit that sits downstream of the multiply reservation station in the Tomasulo core. It accepts one operation when the station raises start, computes the 32-bit result over a fixed, parameterised latency, and then arbitrates for the common data bus (CDB). It broadcasts the result under the issuing station's tag. The unit produces the CDB value/valid traffic that reservation stations and the register file consume.

## Interface
- MUL_CYCLES, default 10: execute latency for MUL, and for any undefined op. Must be ≥ 1.
- DIV_CYCLES, default 40: execute latency for DIV and REM. Must be ≥ 33.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start_in  in  1  station has ready operands. Sampled only in IDLE.
- op_in  in  3  operation: 2 = MUL, 3 = DIVU, 4 = REMU, other values = undefined.
- vj_in  in  32  operand A (multiplicand / dividend).
- vk_in  in  32  operand B (multiplier / divisor).
- tag_in  in  4  tag of the issuing station. Nonzero; 0 means "no producer".
- ready_o  out  1  unit is idle and can accept an operation.
- cdb_req  out  1  requesting the CDB.
- cdb_grant  in  1  arbiter grant. Meaningful only while cdb_req = 1.
- cdb_valid  out  1  broadcast strobe, equal to cdb_req & cdb_grant.
- cdb_tag  out  4  result tag.
- cdb_data  out  32  result value.
- done  out  1  one-cycle pulse telling the station to free its entry. Coincident with cdb_valid.

## Operation
- States: IDLE, EXEC, REQ.
- **IDLE**
  - ready_o = 1.
  - When start_in = 1: capture op, vj, vk and tag; load cnt = LAT−1, where LAT is MUL_CYCLES or DIV_CYCLES according to op; go to EXEC.
  - start_in = 0: stay in IDLE.
- **EXEC**
  - ready_o = 0. cnt decrements every cycle.
  - When cnt == 0, the result is registered into cdb_data and the unit goes to REQ.
  - EXEC therefore lasts exactly LAT cycles.
- **MUL**
  - Result is the low 32 bits of the unsigned product vj*vk.
  - The product may be formed in a single cycle at any point in EXEC; it is held until REQ.
- **DIVU/REMU**
  - Unsigned restoring division, one quotient bit per EXEC cycle, 32 iterations starting in the first EXEC cycle.
  - Uses a 33-bit partial remainder.
  - Remaining EXEC cycles are padding.
  - DIVU returns the quotient; REMU returns the remainder.
  - Divisor 0: DIVU → 0xFFFFFFFF, REMU → vj. No special stall; latency is unchanged.
- **Undefined op**: result 0, latency MUL_CYCLES.
- **REQ**
  - cdb_req = 1. cdb_tag and cdb_data are held stable.
  - When cdb_grant = 1: cdb_valid = 1 and done = 1 in the same cycle, and the next state is IDLE.
  - Without a grant the unit holds REQ indefinitely and the outputs stay unchanged.
- start_in outside IDLE is ignored; there is no queue.
- cdb_grant outside REQ is ignored; cdb_valid stays 0.

## Timing
- Reset values:
  - state IDLE, ready_o = 1.
  - cdb_req = 0, cdb_valid = 0, done = 0.
  - cdb_tag = 0, cdb_data = 0, cnt = 0.
- Asserting rst_n mid-operation aborts immediately: no broadcast and no done.
- Handshake timing:
  - Accept edge at cycle T: EXEC occupies T+1 … T+LAT, and cdb_req is first high in cycle T+LAT+1.
  - With grant already high, cdb_valid and done occur in cycle T+LAT+1; ready_o returns to 1 at T+LAT+2.
- Back-to-back operations: start_in held high across the IDLE return cycle is accepted in that cycle. Minimum spacing between accepts is LAT+2 cycles.
- ready_o and cdb_req are pure functions of state (Moore). cdb_valid and done are combinational on cdb_grant.
- Tag and data are registered; they change only on accept (tag) and at EXEC→REQ (data).

## Test plan
- MUL: op = 2, vj = 7, vk = 6, tag = 3, grant tied high → cdb_req rises 11 cycles after the accept edge, with cdb_data = 42, cdb_tag = 3, and one-cycle cdb_valid/done.
- MUL overflow: vj = 0x10000, vk = 0x10001 → cdb_data = 0x00010000. DIVU 100/7 → 14 after 40 EXEC cycles; REMU 100/7 → 2.
- Divide by zero: DIVU vj = 0x1234, vk = 0 → 0xFFFFFFFF. REMU with the same operands → 0x1234. Latency is 40 in both cases.
- Delayed grant: grant held low for 5 cycles in REQ → cdb_req, cdb_tag and cdb_data are stable for all 5 cycles with cdb_valid = 0. Grant then rises → exactly one cdb_valid pulse, and ready_o = 1 next cycle.
- Start while busy: a second start_in with a different tag during EXEC and during REQ → ignored; only the first tag is broadcast. A start held high through the IDLE return cycle is accepted then.
- Reset mid-EXEC: rst_n low for 1 cycle at EXEC cycle 5 → outputs return to their reset values asynchronously, and no cdb_valid ever appears for that operation.

Source files
------------

// File: rtl/mul_div_exec_unit.sv
// Multi-cycle MUL/DIVU/REMU functional unit for the Tomasulo core.
// It executes one operation at a time, then holds the result on the CDB until the arbiter grants it.
module mul_div_exec_unit #(
    parameter int MUL_CYCLES = 10,
    parameter int DIV_CYCLES = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_in,
    input  logic [2:0]  op_in,
    input  logic [31:0] vj_in,
    input  logic [31:0] vk_in,
    input  logic [3:0]  tag_in,
    output logic        ready_o,
    output logic        cdb_req,
    input  logic        cdb_grant,
    output logic        cdb_valid,
    output logic [3:0]  cdb_tag,
    output logic [31:0] cdb_data,
    output logic        done
);

    localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_LAT);

    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_DIVU = 3'd3;
    localparam logic [2:0] OP_REMU = 3'd4;

    typedef enum logic [1:0] {IDLE, EXEC, REQ} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [2:0]    op_q;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic [31:0]   quo;
    logic [32:0]   rem;
    logic [5:0]    div_iter;

    logic [33:0]   trial;
    logic          borrow;
    logic [31:0]   prod;
    logic [31:0]   result;
    logic          accept;

    assign accept  = (state == IDLE) && start_in;
    assign ready_o = (state == IDLE);
    assign cdb_req = (state == REQ);
    assign cdb_valid = cdb_req & cdb_grant;
    assign done      = cdb_valid;

    // Restoring step: shift the next dividend bit into the remainder and try to subtract the divisor.
    // A zero divisor never borrows, which naturally yields an all-ones quotient and remainder = dividend.
    assign trial  = {rem, quo[31]} - {2'b00, b_q};
    assign borrow = trial[33];
    assign prod   = a_q * b_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
        result = 32'd0;
        case (op_q)
            OP_MUL:  result = prod;
            OP_DIVU: result = quo;
            OP_REMU: result = rem[31:0];
            default: result = 32'd0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_in)   state_nxt = EXEC;
            EXEC:    if (cnt == '0)  state_nxt = REQ;
            REQ:     if (cdb_grant)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            op_q     <= 3'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            quo      <= 32'd0;
            rem      <= 33'd0;
            div_iter <= 6'd0;
            cdb_tag  <= 4'd0;
            cdb_data <= 32'd0;
        end else if (accept) begin
            op_q     <= op_in;
            a_q      <= vj_in;
            b_q      <= vk_in;
            quo      <= vj_in;
            rem      <= 33'd0;
            div_iter <= 6'd0;
            cdb_tag  <= tag_in;
            cnt      <= (op_in == OP_DIVU || op_in == OP_REMU) ? DIV_LOAD : MUL_LOAD;
        end else if (state == EXEC) begin
            if (cnt != '0) cnt <= cnt - CW'(1);
            else           cdb_data <= result;

            // Exactly 32 iterations from the first EXEC cycle; later EXEC cycles are padding.
            if (!div_iter[5]) begin
                div_iter <= div_iter + 6'd1;
                quo      <= {quo[30:0], ~borrow};
                rem      <= borrow ? {rem[31:0], quo[31]} : trial[32:0];
            end
        end
    end

endmodule
